// File: rtl/xadc_vote_filter.sv
// Temporal majority-vote filter over a sliding window of XADC class samples.
// Publishes a debounced class with hysteresis, confidence count and change pulse.
module xadc_vote_filter #(
  parameter int unsigned WINDOW_LOG2 = 3,
  parameter int unsigned THRESHOLD   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_valid,
  input  logic [1:0]             class_in,
  input  logic                   clear,
  output logic [1:0]             class_out,
  output logic                   class_valid,
  output logic                   class_change,
  output logic [WINDOW_LOG2:0]   confidence
);

  localparam int unsigned DEPTH = 1 << WINDOW_LOG2;

  typedef logic [WINDOW_LOG2:0] cnt_t;
  typedef enum logic {FILL, TRACK} state_t;

  localparam cnt_t                   CNT_ONE  = cnt_t'(1);
  localparam cnt_t                   CNT_FULL = cnt_t'(DEPTH);
  localparam cnt_t                   CNT_THR  = cnt_t'(THRESHOLD);
  localparam logic [WINDOW_LOG2-1:0] PTR_ONE  = 1;

  logic [1:0]             win [DEPTH];
  logic [WINDOW_LOG2-1:0] wr_ptr;
  cnt_t                   fill;
  cnt_t                   cnt [4];
  logic                   upd;
  logic                   full;
  logic [1:0]             evicted;

  assign full    = (fill == CNT_FULL);
  assign evicted = win[wr_ptr];

  // Sample storage is not reset; only entries covered by fill are ever counted.
  always_ff @(posedge clk) begin
    if (sample_valid && !clear)
      win[wr_ptr] <= class_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      fill   <= '0;
      upd    <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      fill   <= '0;
      upd    <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      upd <= sample_valid;
      if (sample_valid) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (!full) begin
          fill          <= fill + CNT_ONE;
          cnt[class_in] <= cnt[class_in] + CNT_ONE;
        end else if (evicted != class_in) begin
          cnt[evicted]  <= cnt[evicted] - CNT_ONE;
          cnt[class_in] <= cnt[class_in] + CNT_ONE;
        end
      end
    end
  end

  state_t     state, state_nx;
  logic [1:0] cand;
  logic [1:0] out_nx;
  logic       valid_nx, chg_nx;
  cnt_t       conf_nx;

  // Seeding with class_out and replacing only on a strictly larger count keeps
  // the current class on a tie, else the lowest tied index wins.
  always_comb begin
    cand = class_out;
    for (int unsigned i = 0; i < 4; i++)
      if (cnt[i[1:0]] > cnt[cand]) cand = i[1:0];
  end

  always_comb begin
    state_nx = state;
    out_nx   = class_out;
    valid_nx = class_valid;
    chg_nx   = 1'b0;
    case (state)
      FILL: begin
        if (upd && full) begin
          state_nx = TRACK;
          out_nx   = cand;
          valid_nx = 1'b1;
          chg_nx   = 1'b1;
        end
      end
      TRACK: begin
        if (upd && (cand != class_out) && (cnt[cand] >= CNT_THR)) begin
          out_nx = cand;
          chg_nx = 1'b1;
        end
      end
      default: state_nx = FILL;
    endcase
    conf_nx = (state_nx == TRACK) ? cnt[out_nx] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FILL;
      class_out    <= '0;
      class_valid  <= 1'b0;
      class_change <= 1'b0;
      confidence   <= '0;
    end else if (clear) begin
      state        <= FILL;
      class_out    <= '0;
      class_valid  <= 1'b0;
      class_change <= 1'b0;
      confidence   <= '0;
    end else begin
      state        <= state_nx;
      class_out    <= out_nx;
      class_valid  <= valid_nx;
      class_change <= chg_nx;
      confidence   <= conf_nx;
    end
  end

endmodule

// File: tb/tb_xadc_vote_filter.sv
// Directed bench for xadc_vote_filter: spaced strobes from a vector table plus
// hand-written back-to-back, clear and asynchronous-reset sequences.
module tb_xadc_vote_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_valid = 1'b0;
  logic [1:0] class_in = '0;
  logic       clear = 1'b0;
  logic [1:0] class_out;
  logic       class_valid;
  logic       class_change;
  logic [3:0] confidence;

  int checks = 0;
  int errors = 0;

  xadc_vote_filter #(.WINDOW_LOG2(3), .THRESHOLD(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .class_in     (class_in),
    .clear        (clear),
    .class_out    (class_out),
    .class_valid  (class_valid),
    .class_change (class_change),
    .confidence   (confidence)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cls;
    logic [1:0] e_out;
    logic       e_valid;
    logic       e_chg;
    logic [3:0] e_conf;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input int o, input int v, input int c, input int f);
    chk({tag, ".class_out"},    int'(class_out),    o);
    chk({tag, ".class_valid"},  int'(class_valid),  v);
    chk({tag, ".class_change"}, int'(class_change), c);
    chk({tag, ".confidence"},   int'(confidence),   f);
  endtask

  // One strobe per row, 5 cycles apart; outputs checked two edges after the
  // capturing edge, and the change pulse must be gone one cycle later.
  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      class_in     = vecs[r].cls;
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      chk_outs($sformatf("row%0d", r), vecs[r].e_out, vecs[r].e_valid,
               vecs[r].e_chg, vecs[r].e_conf);
      @(negedge clk);
      chk($sformatf("row%0d.pulse_end", r), int'(class_change), 0);
      @(negedge clk);
    end
  endtask

  int burst_conf [20];

  initial begin
    // rows 0-7: fill with class 2; rows 8-12: class 1 erodes then takes over
    for (int i = 0; i < 7; i++) vecs[i] = '{2'd2, 2'd0, 1'b0, 1'b0, 4'd0};
    vecs[7]  = '{2'd2, 2'd2, 1'b1, 1'b1, 4'd8};
    vecs[8]  = '{2'd1, 2'd2, 1'b1, 1'b0, 4'd7};
    vecs[9]  = '{2'd1, 2'd2, 1'b1, 1'b0, 4'd6};
    vecs[10] = '{2'd1, 2'd2, 1'b1, 1'b0, 4'd5};
    vecs[11] = '{2'd1, 2'd2, 1'b1, 1'b0, 4'd4};
    vecs[12] = '{2'd1, 2'd1, 1'b1, 1'b1, 4'd5};
    // rows 13-20: refill with class 3 after a clear
    for (int i = 13; i < 20; i++) vecs[i] = '{2'd3, 2'd0, 1'b0, 1'b0, 4'd0};
    vecs[20] = '{2'd3, 2'd3, 1'b1, 1'b1, 4'd8};

    // class-1 count after each burst strobe: window starts [1,1,1,1,1,2,2,2] at ptr 5
    burst_conf = '{5, 6, 6, 5, 4, 4, 3, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};

    repeat (3) @(negedge clk);
    chk_outs("reset", 0, 0, 0, 0);
    rst = 1'b1;

    run_rows(0, 12);

    // back-to-back cycling 0..3; tie at 2 each keeps class 1
    for (int j = 0; j < 22; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        chk($sformatf("burst%0d.conf", j - 2), int'(confidence), burst_conf[j - 2]);
        chk($sformatf("burst%0d.out", j - 2), int'(class_out), 1);
        chk($sformatf("burst%0d.chg", j - 2), int'(class_change), 0);
      end
      if (j < 20) begin
        sample_valid = 1'b1;
        class_in     = 2'(j % 4);
      end else begin
        sample_valid = 1'b0;
      end
    end
    chk("burst.cnt_sum", int'(dut.cnt[0]) + int'(dut.cnt[1]) + int'(dut.cnt[2]) + int'(dut.cnt[3]), 8);
    chk("burst.cnt0", int'(dut.cnt[0]), 2);
    chk("burst.cnt3", int'(dut.cnt[3]), 2);

    // clear with a concurrent strobe: sample dropped, outputs zero next cycle
    @(negedge clk);
    sample_valid = 1'b1;
    class_in     = 2'd3;
    clear        = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    clear        = 1'b0;
    chk_outs("clear", 0, 0, 0, 0);
    @(negedge clk);
    chk_outs("clear+1", 0, 0, 0, 0);
    run_rows(13, 20);

    // asynchronous reset mid-burst
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      class_in     = 2'd2;
    end
    @(posedge clk);
    #2;
    rst          = 1'b0;
    sample_valid = 1'b0;
    #1;
    chk_outs("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    run_rows(0, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
